// File: rtl/stack_sequencer_pkg.sv
// Shared types and codes for the stack sequencer and the memory stage it drives.
// Holds the state encoding, op encodings and the address/write-source select codes.
package stack_seq_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        PUSH_R     = 4'd1,
        POP_R      = 4'd2,
        PUSH_FLAGS = 4'd3,
        PUSH_HI    = 4'd4,
        PUSH_LO    = 4'd5,
        POP_LO     = 4'd6,
        POP_HI     = 4'd7,
        LOAD_PC    = 4'd8,
        POP_FLAGS  = 4'd9
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_RTI  = 3'b101;

    localparam logic [1:0] SEL_SP     = 2'b10;
    localparam logic [1:0] WSRC_FLAGS = 2'b00;
    localparam logic [1:0] WSRC_PCHI  = 2'b01;
    localparam logic [1:0] WSRC_PCLO  = 2'b10;
    localparam logic [1:0] WSRC_REG   = 2'b11;

    // Beats that end a sequence; the chained-interrupt decision is taken here.
    function automatic logic is_done_beat(input state_t s);
        logic r;
        case (s)
            PUSH_R, POP_R, PUSH_LO, LOAD_PC, POP_FLAGS: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Request and memory-stage control bundle of the stack sequencer.
// master = sequencer side, slave = upstream/memory-stage side.
interface stack_sequencer_if;

    logic       op_valid;
    logic [2:0] op;
    logic       int_req;
    logic       busy;
    logic       done;
    logic       int_ack;
    logic       memory_read;
    logic       memory_write;
    logic       memory_push;
    logic       memory_pop;
    logic [1:0] memory_address_select;
    logic [1:0] memory_write_src_select;
    logic       pc_choose_memory;
    logic       interrupt;
    logic       flags_restore;

    modport master (
        input  op_valid, op, int_req,
        output busy, done, int_ack,
        output memory_read, memory_write, memory_push, memory_pop,
        output memory_address_select, memory_write_src_select,
        output pc_choose_memory, interrupt, flags_restore
    );

    modport slave (
        output op_valid, op, int_req,
        input  busy, done, int_ack,
        input  memory_read, memory_write, memory_push, memory_pop,
        input  memory_address_select, memory_write_src_select,
        input  pc_choose_memory, interrupt, flags_restore
    );

endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle stack sequencer: splits PUSH/POP/CALL/RET/RTI and interrupt entry
// into 16-bit memory beats. All outputs decode registered state only.
module stack_sequencer
    import stack_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    stack_sequencer_if.master  bus
);

    state_t state_r;
    state_t state_next_s;
    logic   int_pending_r;
    logic   int_pending_next_s;
    logic   rti_mode_r;
    logic   rti_mode_next_s;
    logic   int_mode_r;
    logic   int_mode_next_s;
    logic   irq_s;

    assign irq_s = bus.int_req | int_pending_r;

    // State and mode flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            int_pending_r <= 1'b0;
            rti_mode_r    <= 1'b0;
            int_mode_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            int_pending_r <= int_pending_next_s;
            rti_mode_r    <= rti_mode_next_s;
            int_mode_r    <= int_mode_next_s;
        end
    end

    // Next-state: interrupt beats any op in IDLE and chains directly after a done beat.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (irq_s) begin
                    state_next_s = PUSH_FLAGS;
                end else if (bus.op_valid) begin
                    case (bus.op)
                        OP_PUSH:        state_next_s = PUSH_R;
                        OP_POP:         state_next_s = POP_R;
                        OP_CALL:        state_next_s = PUSH_HI;
                        OP_RET, OP_RTI: state_next_s = POP_LO;
                        default:        state_next_s = IDLE;
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end
            PUSH_FLAGS: state_next_s = PUSH_HI;
            PUSH_HI:    state_next_s = PUSH_LO;
            POP_LO:     state_next_s = POP_HI;
            POP_HI:     state_next_s = rti_mode_r ? POP_FLAGS : LOAD_PC;
            PUSH_R, POP_R, PUSH_LO, LOAD_PC, POP_FLAGS:
                        state_next_s = irq_s ? PUSH_FLAGS : IDLE;
            default:    state_next_s = IDLE;
        endcase
    end

    // Pending interrupt and return-mode bookkeeping.
    always_comb begin
        int_pending_next_s = int_pending_r;
        rti_mode_next_s    = rti_mode_r;
        int_mode_next_s    = int_mode_r;
        if (state_next_s == PUSH_FLAGS) begin
            int_pending_next_s = 1'b0;
        end else if (bus.int_req && (state_r != IDLE)) begin
            int_pending_next_s = 1'b1;
        end else begin
            int_pending_next_s = int_pending_r;
        end
        if (state_next_s == IDLE) begin
            rti_mode_next_s = 1'b0;
            int_mode_next_s = 1'b0;
        end else if (state_next_s == PUSH_FLAGS) begin
            rti_mode_next_s = 1'b0;
            int_mode_next_s = 1'b1;
        end else if ((state_r == IDLE) && (state_next_s == POP_LO)) begin
            rti_mode_next_s = (bus.op == OP_RTI);
            int_mode_next_s = 1'b0;
        end else begin
            rti_mode_next_s = rti_mode_r;
            int_mode_next_s = int_mode_r;
        end
    end

    // Output decode of the registered state.
    always_comb begin
        bus.busy                    = (state_r != IDLE);
        bus.done                    = is_done_beat(state_r);
        bus.int_ack                 = 1'b0;
        bus.memory_read             = 1'b0;
        bus.memory_write            = 1'b0;
        bus.memory_push             = 1'b0;
        bus.memory_pop              = 1'b0;
        bus.memory_address_select   = 2'b00;
        bus.memory_write_src_select = 2'b00;
        bus.pc_choose_memory        = 1'b0;
        bus.interrupt               = 1'b0;
        bus.flags_restore           = 1'b0;
        case (state_r)
            PUSH_R: begin
                bus.memory_write            = 1'b1;
                bus.memory_push             = 1'b1;
                bus.memory_address_select   = SEL_SP;
                bus.memory_write_src_select = WSRC_REG;
            end
            PUSH_FLAGS: begin
                bus.memory_write            = 1'b1;
                bus.memory_push             = 1'b1;
                bus.memory_address_select   = SEL_SP;
                bus.memory_write_src_select = WSRC_FLAGS;
                bus.int_ack                 = 1'b1;
            end
            PUSH_HI: begin
                bus.memory_write            = 1'b1;
                bus.memory_push             = 1'b1;
                bus.memory_address_select   = SEL_SP;
                bus.memory_write_src_select = WSRC_PCHI;
            end
            PUSH_LO: begin
                bus.memory_write            = 1'b1;
                bus.memory_push             = 1'b1;
                bus.memory_address_select   = SEL_SP;
                bus.memory_write_src_select = WSRC_PCLO;
                bus.interrupt               = int_mode_r;
            end
            POP_R, POP_LO, POP_HI: begin
                bus.memory_read             = 1'b1;
                bus.memory_pop              = 1'b1;
                bus.memory_address_select   = SEL_SP;
            end
            LOAD_PC: begin
                bus.pc_choose_memory        = 1'b1;
            end
            POP_FLAGS: begin
                bus.memory_read             = 1'b1;
                bus.memory_pop              = 1'b1;
                bus.memory_address_select   = SEL_SP;
                bus.pc_choose_memory        = 1'b1;
                bus.flags_restore           = 1'b1;
            end
            default: begin
                bus.int_ack                 = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a small SP/stack/PC memory-stage model.
module tb_stack_sequencer;
    import stack_seq_pkg::*;

    logic clk;
    logic reset;
    stack_sequencer_if sif ();

    stack_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory-stage model driven purely by the control outputs.
    logic [15:0] mem [0:255];
    logic [7:0]  sp;
    logic [31:0] pc;
    logic [31:0] shreg;
    logic [2:0]  flags;
    logic [15:0] reg_data;
    logic [15:0] wdata;
    logic        model_init;
    logic        load_tb;
    logic [31:0] pc_init;
    logic [2:0]  flags_init;
    logic [14:0] outs;

    assign outs = {sif.busy, sif.done, sif.int_ack, sif.memory_read, sif.memory_write,
                   sif.memory_push, sif.memory_pop, sif.memory_address_select,
                   sif.memory_write_src_select, sif.pc_choose_memory, sif.interrupt,
                   sif.flags_restore};

    always_comb begin
        case (sif.memory_write_src_select)
            2'b00:   wdata = {13'd0, flags};
            2'b01:   wdata = pc[31:16];
            2'b10:   wdata = pc[15:0];
            default: wdata = reg_data;
        endcase
    end

    always @(posedge clk) begin
        if (model_init) begin
            sp    <= 8'd128;
            pc    <= pc_init;
            flags <= flags_init;
        end else if (load_tb) begin
            pc    <= pc_init;
            flags <= flags_init;
        end else begin
            if (sif.memory_write && sif.memory_push) begin
                mem[sp - 8'd1] <= wdata;
                sp             <= sp - 8'd1;
            end
            if (sif.memory_read && sif.memory_pop) begin
                shreg <= {mem[sp], shreg[31:16]};
                sp    <= sp + 8'd1;
            end
            if (sif.interrupt) pc <= 32'd0;
            else if (sif.pc_choose_memory) pc <= shreg;
            if (sif.flags_restore) flags <= mem[sp][2:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] p, input logic [2:0] f);
        pc_init    = p;
        flags_init = f;
        load_tb    = 1'b1;
        tick();
        load_tb    = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o);
        sif.op       = o;
        sif.op_valid = 1'b1;
        tick();
        sif.op_valid = 1'b0;
    endtask

    int acks;

    initial begin
        reset        = 1'b1;
        sif.op_valid = 1'b0;
        sif.op       = 3'b000;
        sif.int_req  = 1'b0;
        reg_data     = 16'h0000;
        model_init   = 1'b1;
        load_tb      = 1'b0;
        pc_init      = 32'd0;
        flags_init   = 3'd0;
        tick();
        tick();
        model_init = 1'b0;
        check("reset_outs", {17'd0, outs}, 32'd0);
        reset = 1'b0;
        tick();

        // PUSH: single write beat
        reg_data = 16'h1234;
        issue(OP_PUSH);
        check("push_write", {31'd0, sif.memory_write}, 32'd1);
        check("push_push",  {31'd0, sif.memory_push}, 32'd1);
        check("push_wsrc",  {30'd0, sif.memory_write_src_select}, 32'd3);
        check("push_addr",  {30'd0, sif.memory_address_select}, 32'd2);
        check("push_done",  {31'd0, sif.done}, 32'd1);
        check("push_busy",  {31'd0, sif.busy}, 32'd1);
        tick();
        check("push_idle",  {31'd0, sif.busy}, 32'd0);
        check("push_mem",   {16'd0, mem[sp]}, 32'h0000_1234);

        // CALL pushes pc 0x00012345
        load(32'h0001_2345, 3'd0);
        issue(OP_CALL);
        check("call_b1_wsrc", {30'd0, sif.memory_write_src_select}, 32'd1);
        check("call_b1_done", {31'd0, sif.done}, 32'd0);
        check("call_b1_int",  {31'd0, sif.interrupt}, 32'd0);
        tick();
        check("call_b2_wsrc", {30'd0, sif.memory_write_src_select}, 32'd2);
        check("call_b2_done", {31'd0, sif.done}, 32'd1);
        check("call_b2_int",  {31'd0, sif.interrupt}, 32'd0);
        check("call_b2_busy", {31'd0, sif.busy}, 32'd1);
        tick();
        check("call_idle",    {31'd0, sif.busy}, 32'd0);

        // RET restores it
        load(32'd0, 3'd0);
        issue(OP_RET);
        check("ret_b1_read", {31'd0, sif.memory_read}, 32'd1);
        check("ret_b1_pop",  {31'd0, sif.memory_pop}, 32'd1);
        check("ret_b1_addr", {30'd0, sif.memory_address_select}, 32'd2);
        tick();
        check("ret_b2_read", {31'd0, sif.memory_read}, 32'd1);
        check("ret_b2_pcm",  {31'd0, sif.pc_choose_memory}, 32'd0);
        tick();
        check("ret_b3_pcm",  {31'd0, sif.pc_choose_memory}, 32'd1);
        check("ret_b3_done", {31'd0, sif.done}, 32'd1);
        check("ret_b3_read", {31'd0, sif.memory_read}, 32'd0);
        tick();
        check("ret_idle",    {31'd0, sif.busy}, 32'd0);
        check("ret_pc",      pc, 32'h0001_2345);

        // Reset held two cycles inside CALL PUSH_LO
        issue(OP_CALL);
        tick();
        check("rst_in_pushlo", {30'd0, sif.memory_write_src_select}, 32'd2);
        reset = 1'b1;
        tick();
        tick();
        check("rst_mid_outs", {17'd0, outs}, 32'd0);
        reset = 1'b0;
        tick();
        check("rst_after_outs", {17'd0, outs}, 32'd0);

        // Interrupt with a simultaneous PUSH request: interrupt wins
        load(32'hABCD_0042, 3'b101);
        sif.int_req = 1'b1;
        issue(OP_PUSH);
        sif.int_req = 1'b0;
        check("int_ack",      {31'd0, sif.int_ack}, 32'd1);
        check("int_f_wsrc",   {30'd0, sif.memory_write_src_select}, 32'd0);
        check("int_f_write",  {31'd0, sif.memory_write}, 32'd1);
        check("int_f_done",   {31'd0, sif.done}, 32'd0);
        tick();
        check("int_hi_wsrc",  {30'd0, sif.memory_write_src_select}, 32'd1);
        check("int_hi_ack",   {31'd0, sif.int_ack}, 32'd0);
        tick();
        check("int_lo_wsrc",  {30'd0, sif.memory_write_src_select}, 32'd2);
        check("int_lo_int",   {31'd0, sif.interrupt}, 32'd1);
        check("int_lo_done",  {31'd0, sif.done}, 32'd1);
        tick();
        check("int_idle",     {31'd0, sif.busy}, 32'd0);
        check("int_pc_zero",  pc, 32'd0);

        // RTI returns pc and flags
        load(32'd0, 3'd0);
        issue(OP_RTI);
        check("rti_b1_read", {31'd0, sif.memory_read}, 32'd1);
        tick();
        check("rti_b2_pcm",  {31'd0, sif.pc_choose_memory}, 32'd0);
        tick();
        check("rti_b3_pcm",  {31'd0, sif.pc_choose_memory}, 32'd1);
        check("rti_b3_fr",   {31'd0, sif.flags_restore}, 32'd1);
        check("rti_b3_read", {31'd0, sif.memory_read}, 32'd1);
        check("rti_b3_done", {31'd0, sif.done}, 32'd1);
        tick();
        check("rti_idle",    {31'd0, sif.busy}, 32'd0);
        check("rti_pc",      pc, 32'hABCD_0042);
        check("rti_flags",   {29'd0, flags}, 32'd5);

        // int_req during RET POP_HI chains into interrupt entry after LOAD_PC
        load(32'h5555_AAAA, 3'd0);
        issue(OP_CALL);
        tick();
        tick();
        load(32'd0, 3'd0);
        issue(OP_RET);
        tick();
        sif.int_req = 1'b1;
        tick();
        sif.int_req = 1'b0;
        check("chain_ld_done", {31'd0, sif.done}, 32'd1);
        check("chain_ld_pcm",  {31'd0, sif.pc_choose_memory}, 32'd1);
        check("chain_ld_ack",  {31'd0, sif.int_ack}, 32'd0);
        acks = 0;
        tick();
        check("chain_pf_ack",  {31'd0, sif.int_ack}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            acks += int'(sif.int_ack);
            tick();
        end
        check("chain_ack_once", acks, 32'd1);
        check("chain_idle",     {31'd0, sif.busy}, 32'd0);
        check("chain_pc_zero",  pc, 32'd0);
        check("chain_pushed_lo", {16'd0, mem[sp]}, 32'h0000_AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
